// File: rtl/ysyx_ctrl_pkg.sv
// Shared definitions for the NPC core sequencer: state encoding, reset PC, nop word.
// Pure declarations, no timing.
// No handshakes of its own.
package ysyx_ctrl_pkg;

  localparam logic [2:0] ST_FREQ  = 3'd0;
  localparam logic [2:0] ST_FWAIT = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MREQ  = 3'd3;
  localparam logic [2:0] ST_MWAIT = 3'd4;
  localparam logic [2:0] ST_WB    = 3'd5;
  localparam logic [2:0] ST_HALT  = 3'd6;
  localparam logic [2:0] ST_ERROR = 3'd7;

  typedef enum logic [2:0] {
    FREQ  = ST_FREQ,
    FWAIT = ST_FWAIT,
    EXEC  = ST_EXEC,
    MREQ  = ST_MREQ,
    MWAIT = ST_MWAIT,
    WB    = ST_WB,
    HALT  = ST_HALT,
    ERROR = ST_ERROR
  } ctrl_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  // States in which the sequencer is stalled on an external bus
  function automatic logic is_wait_state(input ctrl_state_t s);
    return (s == FREQ) || (s == FWAIT) || (s == MREQ) || (s == MWAIT);
  endfunction

endpackage

// File: rtl/ysyx_ctrl_wdt.sv
// Bus watchdog: counts stalled cycles, flags expiry once the count reaches TIMEOUT-1.
// Expire is a compare on the registered count, valid in the same cycle.
// No handshake; clr dominates en.
module ysyx_ctrl_wdt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count while enabled, saturate at LAST, restart on every clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/ysyx_core_ctrl.sv
// Multi-cycle NPC sequencer: fetch, decode hold, load/store, writeback, PC commit; optional perf counters (YSYX_CTRL_PERF_EN).
// Latency with zero-wait bus: ALU/branch 4 cycles, load/store 6 cycles.
// Valids held until ready; all valids are state-decoded, so no ready->valid combinational path; watchdog traps stuck buses.
module ysyx_core_ctrl
  import ysyx_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        dec_rf_wr_en,
  input  logic [2:0]  dec_dm_rd_sel,
  input  logic [1:0]  dec_dm_wr_sel,
  input  logic        dec_is_ebreak,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  output logic        lsu_we,
  input  logic        lsu_rsp_valid,
  output logic        rf_we,
  output logic        halt,
  output logic        bus_err
`ifdef YSYX_CTRL_PERF_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  ctrl_state_t state;
  logic        is_store;
  logic        wb_wr;
  logic        wait_st;
  logic        wait_done;
  logic        wdt_expire;

  assign wait_st = is_wait_state(state);

  // Handshake that lets the current wait state advance this cycle
  always_comb begin
    wait_done = 1'b0;
    case (state)
      FREQ:    wait_done = ifu_req_ready;
      FWAIT:   wait_done = ifu_rsp_valid;
      MREQ:    wait_done = lsu_req_ready;
      MWAIT:   wait_done = lsu_rsp_valid;
      default: wait_done = 1'b0;
    endcase
  end

  // Every exit from a wait state goes through wait_done or expiry, so clearing
  // on those (and outside wait states) restarts the count on each state change.
  ysyx_ctrl_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!wait_st || wait_done),
    .en     (wait_st),
    .expire (wdt_expire)
  );

  // Sequencer FSM: completion is checked before expiry so a late handshake still wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FREQ;
      pc       <= RESET_PC;
      inst     <= NOP_INST;
      is_store <= 1'b0;
      wb_wr    <= 1'b0;
    end else begin
      case (state)
        FREQ: begin
          if (ifu_req_ready)   state <= FWAIT;
          else if (wdt_expire) state <= ERROR;
        end
        FWAIT: begin
          if (ifu_rsp_valid) begin
            inst  <= ifu_rsp_data;
            state <= EXEC;
          end else if (wdt_expire) begin
            state <= ERROR;
          end
        end
        EXEC: begin
          if (dec_is_ebreak) begin
            state <= HALT;
          end else if (dec_dm_wr_sel != 2'd0) begin
            is_store <= 1'b1;
            wb_wr    <= 1'b0;
            state    <= MREQ;
          end else if (dec_dm_rd_sel != 3'd0) begin
            is_store <= 1'b0;
            wb_wr    <= dec_rf_wr_en;
            state    <= MREQ;
          end else begin
            is_store <= 1'b0;
            wb_wr    <= dec_rf_wr_en;
            state    <= WB;
          end
        end
        MREQ: begin
          if (lsu_req_ready)   state <= MWAIT;
          else if (wdt_expire) state <= ERROR;
        end
        MWAIT: begin
          if (lsu_rsp_valid)   state <= WB;
          else if (wdt_expire) state <= ERROR;
        end
        WB: begin
          pc    <= next_pc;
          state <= FREQ;
        end
        default: state <= state;
      endcase
    end
  end

  // Reset state is FREQ, so the fetch valid is also qualified by rst_n to stay low while in reset
  assign ifu_req_valid = rst_n && (state == FREQ);
  assign ifu_addr      = pc;
  assign lsu_req_valid = (state == MREQ);
  assign lsu_we        = (state == MREQ) && is_store;
  assign rf_we         = (state == WB) && wb_wr;
  assign halt          = (state == HALT);
  assign bus_err       = (state == ERROR);

`ifdef YSYX_CTRL_PERF_EN
  // Cycle counter freezes in the terminal states; retire counts writeback cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycle   <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if ((state != HALT) && (state != ERROR)) perf_cycle <= perf_cycle + 64'd1;
      if (state == WB) perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_core_ctrl.sv
// Scoreboard bench for ysyx_core_ctrl: directed instruction sequences, expected bus/writeback events queued.
// Monitor compares each cycle in which the DUT asserts a valid or rf_we.
// Bus handshakes are driven with programmable delays.
module tb_ysyx_core_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        dec_rf_wr_en;
  logic [2:0]  dec_dm_rd_sel;
  logic [1:0]  dec_dm_wr_sel;
  logic        dec_is_ebreak;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_we;
  logic        lsu_rsp_valid;
  logic        rf_we;
  logic        halt;
  logic        bus_err;

  ysyx_core_ctrl #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .inst          (inst),
    .pc            (pc),
    .next_pc       (next_pc),
    .dec_rf_wr_en  (dec_rf_wr_en),
    .dec_dm_rd_sel (dec_dm_rd_sel),
    .dec_dm_wr_sel (dec_dm_wr_sel),
    .dec_is_ebreak (dec_is_ebreak),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_we        (lsu_we),
    .lsu_rsp_valid (lsu_rsp_valid),
    .rf_we         (rf_we),
    .halt          (halt),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ifu_v;
    logic [31:0] addr;
    logic        lsu_v;
    logic        lsu_w;
    logic        rf_w;
    logic [31:0] cur_pc;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc_cnt;
  logic [31:0] pc_model;

  function automatic ev_t mk(input logic iv, input logic lv, input logic lw, input logic rw, input logic [31:0] p);
    ev_t e;
    e.ifu_v  = iv;
    e.addr   = p;
    e.lsu_v  = lv;
    e.lsu_w  = lw;
    e.rf_w   = rw;
    e.cur_pc = p;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // Monitor: every cycle with an asserted valid or strobe must match the queue head
  always @(negedge clk) begin
    ev_t got;
    ev_t exp;
    if (rst_n && (ifu_req_valid || lsu_req_valid || rf_we)) begin
      got.ifu_v  = ifu_req_valid;
      got.addr   = ifu_addr;
      got.lsu_v  = lsu_req_valid;
      got.lsu_w  = lsu_we;
      got.rf_w   = rf_we;
      got.cur_pc = pc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ifu_v=%b addr=%h lsu_v=%b we=%b rf_we=%b pc=%h with no event expected",
                 got.ifu_v, got.addr, got.lsu_v, got.lsu_w, got.rf_w, got.cur_pc);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_event: got ifu_v=%b addr=%h lsu_v=%b we=%b rf_we=%b pc=%h expected ifu_v=%b addr=%h lsu_v=%b we=%b rf_we=%b pc=%h",
                   got.ifu_v, got.addr, got.lsu_v, got.lsu_w, got.rf_w, got.cur_pc,
                   exp.ifu_v, exp.addr, exp.lsu_v, exp.lsu_w, exp.rf_w, exp.cur_pc);
        end
      end
    end
  end

  // kind: 0 alu, 1 load, 2 store, 3 ebreak. Entered at posedge+1 with DUT in FREQ.
  task automatic run_instr(input string name, input logic [31:0] iword, input int kind, input logic wr_en,
                           input int ifu_rdy_dly, input int ifu_rsp_dly, input int lsu_rdy_dly,
                           input int lsu_rsp_dly, input int exp_cycles);
    logic mem;
    logic st;
    mem = (kind == 1) || (kind == 2);
    st  = (kind == 2);
    dec_rf_wr_en  = wr_en;
    dec_dm_rd_sel = (kind == 1) ? 3'd2 : 3'd0;
    dec_dm_wr_sel = st ? 2'd2 : 2'd0;
    dec_is_ebreak = (kind == 3);
    next_pc       = pc_model + 32'd4;
    for (int i = 0; i <= ifu_rdy_dly; i++) sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, pc_model));
    if (mem) for (int i = 0; i <= lsu_rdy_dly; i++) sb.push_back(mk(1'b0, 1'b1, st, 1'b0, pc_model));
    if ((kind != 3) && wr_en && !st) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, pc_model));
    cyc_cnt = 0;
    ifu_req_ready = 1'b0;
    repeat (ifu_rdy_dly) tick();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    repeat (ifu_rsp_dly) tick();
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = iword;
    tick();
    ifu_rsp_valid = 1'b0;
    chk({name, "_inst"}, inst, iword);
    if (kind == 3) begin
      tick();
      chk({name, "_cycles"}, cyc_cnt, exp_cycles);
      chk({name, "_halt"}, {31'd0, halt}, 32'd1);
      chk({name, "_pc_frozen"}, pc, pc_model);
    end else begin
      if (mem) begin
        tick();
        repeat (lsu_rdy_dly) tick();
        lsu_req_ready = 1'b1;
        tick();
        lsu_req_ready = 1'b0;
        repeat (lsu_rsp_dly) tick();
        lsu_rsp_valid = 1'b1;
        tick();
        lsu_rsp_valid = 1'b0;
      end else begin
        tick();
      end
      tick();
      pc_model = pc_model + 32'd4;
      chk({name, "_cycles"}, cyc_cnt, exp_cycles);
      chk({name, "_pc"}, pc, pc_model);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pc_model = RST_PC;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b1;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = 32'd0;
    next_pc       = 32'd0;
    dec_rf_wr_en  = 1'b0;
    dec_dm_rd_sel = 3'd0;
    dec_dm_wr_sel = 2'd0;
    dec_is_ebreak = 1'b0;
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    pc_model      = RST_PC;
    #3;
    rst_n = 1'b0;
    #4;
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, NOP);
    chk("rst_valids", {29'd0, ifu_req_valid, lsu_req_valid, rf_we}, 32'd0);
    chk("rst_status", {30'd0, halt, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // addi, zero-wait bus
    run_instr("addi", 32'h0010_0093, 0, 1'b1, 0, 0, 0, 0, 4);
    // sw, lsu ready held low 3 cycles
    run_instr("sw", 32'h0020_a023, 2, 1'b0, 0, 0, 3, 0, 9);
    // lw, response 5 cycles into MWAIT
    run_instr("lw", 32'h0000_a103, 1, 1'b1, 0, 0, 0, 4, 10);
    // fetch response in the last cycle before timeout, fetch ready delayed too
    run_instr("late_fetch", 32'h0041_0113, 0, 1'b1, 2, 7, 0, 0, 13);

    // reset asserted while a load sits in MWAIT
    dec_rf_wr_en  = 1'b1;
    dec_dm_rd_sel = 3'd2;
    dec_dm_wr_sel = 2'd0;
    dec_is_ebreak = 1'b0;
    next_pc       = pc_model + 32'd4;
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, pc_model));
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, pc_model));
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0040_a183;
    tick();
    ifu_rsp_valid = 1'b0;
    tick();
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_inst", inst, NOP);
    chk("midrst_valids", {29'd0, ifu_req_valid, lsu_req_valid, rf_we}, 32'd0);
    pc_model = RST_PC;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr("refetch", 32'h0010_0093, 0, 1'b1, 0, 0, 0, 0, 4);

    // ebreak: terminal, no further fetch
    run_instr("ebreak", 32'h0010_0073, 3, 1'b0, 0, 0, 0, 0, 3);
    ifu_req_ready = 1'b1;
    repeat (5) tick();
    ifu_req_ready = 1'b0;
    chk("halt_sticky", {31'd0, halt}, 32'd1);
    chk("halt_pc", pc, 32'h8000_0004);
    chk("halt_no_fetch", {31'd0, ifu_req_valid}, 32'd0);

    // watchdog: fetch response never arrives
    do_reset();
    chk("post_halt_rst", {30'd0, halt, bus_err}, 32'd0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, RST_PC));
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    repeat (7) tick();
    chk("wdt_not_yet", {31'd0, bus_err}, 32'd0);
    tick();
    chk("wdt_expired", {31'd0, bus_err}, 32'd1);
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'h0010_0073;
    tick();
    ifu_rsp_valid = 1'b0;
    ifu_req_ready = 1'b1;
    repeat (3) tick();
    ifu_req_ready = 1'b0;
    chk("err_inst_frozen", inst, NOP);
    chk("err_sticky", {30'd0, halt, bus_err}, 32'd1);
    chk("err_pc", pc, RST_PC);

    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
